alu_issue_stage: RTL and testbench

//  Pipeline stage directly upstream of the ALU: accepts one decoded uop per cycle,

---
 rtl/alu_issue_stage.sv | 150 +++++++++++++++
 tb/tb_alu_issue_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: operand-resolve / issue register in front of the ALU.
// Resolves lhs/rhs from regfile, PC, immediate or EX/WB bypass, blocks on
// load-use hazards and presents a registered uop with a valid/ready handshake.
// Optional build macro: ALU_ISSUE_SKID_EN adds a 1-entry skid buffer so that
// in_ready no longer depends combinationally on out_ready.
module alu_issue_stage #(
  parameter int unsigned REG_W   = 32,
  parameter int unsigned OP_W    = 4,
  parameter int unsigned RADDR_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    in_op,
  input  logic [RADDR_W-1:0] in_rs1,
  input  logic [RADDR_W-1:0] in_rs2,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic               in_lhs_sel,
  input  logic               in_rhs_sel,
  input  logic [REG_W-1:0]   in_pc,
  input  logic [REG_W-1:0]   in_imm,
  input  logic [REG_W-1:0]   rf_rs1_data,
  input  logic [REG_W-1:0]   rf_rs2_data,
  input  logic               ex_fwd_valid,
  input  logic [RADDR_W-1:0] ex_fwd_rd,
  input  logic [REG_W-1:0]   ex_fwd_data,
  input  logic               ex_fwd_load,
  input  logic               wb_fwd_valid,
  input  logic [RADDR_W-1:0] wb_fwd_rd,
  input  logic [REG_W-1:0]   wb_fwd_data,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OP_W-1:0]    out_op,
  output logic [REG_W-1:0]   out_lhs,
  output logic [REG_W-1:0]   out_rhs,
  output logic [RADDR_W-1:0] out_rd
);

  typedef struct packed {
    logic [OP_W-1:0]    op;
    logic [REG_W-1:0]   lhs;
    logic [REG_W-1:0]   rhs;
    logic [RADDR_W-1:0] rd;
  } uop_t;

  logic       use1, use2, hazard, accept;
  logic       ex_hit1, ex_hit2, wb_hit1, wb_hit2;
  logic [REG_W-1:0] rs1_val, rs2_val;
  uop_t       uop_d;
  uop_t       out_q;
  logic       out_valid_q;

  // Load-use hazard: EX holds a load whose result a register operand needs.
  always_comb begin
    use1   = !in_lhs_sel && (in_rs1 != '0);
    use2   = !in_rhs_sel && (in_rs2 != '0);
    hazard = in_valid && ex_fwd_valid && ex_fwd_load && (ex_fwd_rd != '0) &&
             ((use1 && (ex_fwd_rd == in_rs1)) || (use2 && (ex_fwd_rd == in_rs2)));
  end

  // Operand resolve: x0, then EX bypass (non-load only), then WB bypass, then regfile.
  always_comb begin
    ex_hit1 = ex_fwd_valid && !ex_fwd_load && (ex_fwd_rd == in_rs1);
    ex_hit2 = ex_fwd_valid && !ex_fwd_load && (ex_fwd_rd == in_rs2);
    wb_hit1 = wb_fwd_valid && (wb_fwd_rd == in_rs1);
    wb_hit2 = wb_fwd_valid && (wb_fwd_rd == in_rs2);

    rs1_val = rf_rs1_data;
    if (in_rs1 == '0)  rs1_val = '0;
    else if (ex_hit1)  rs1_val = ex_fwd_data;
    else if (wb_hit1)  rs1_val = wb_fwd_data;

    rs2_val = rf_rs2_data;
    if (in_rs2 == '0)  rs2_val = '0;
    else if (ex_hit2)  rs2_val = ex_fwd_data;
    else if (wb_hit2)  rs2_val = wb_fwd_data;

    uop_d.op  = in_op;
    uop_d.lhs = in_lhs_sel ? in_pc : rs1_val;
    uop_d.rhs = in_rhs_sel ? in_imm : rs2_val;
    uop_d.rd  = in_rd;
  end

  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_op    = out_q.op;
  assign out_lhs   = out_q.lhs;
  assign out_rhs   = out_q.rhs;
  assign out_rd    = out_q.rd;

`ifdef ALU_ISSUE_SKID_EN
  uop_t skid_q;
  logic skid_valid_q;

  // Registered space term: only a full skid blocks new uops.
  always_comb begin
    in_ready = !flush && !hazard && !skid_valid_q;
  end

  // Output + skid: refill output from skid first to keep order, park new uop in skid on stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (accept) begin
        out_q       <= uop_d;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (accept) begin
      skid_q       <= uop_d;
      skid_valid_q <= 1'b1;
    end
  end
`else
  // Single-entry stage: room whenever the output is empty or being consumed.
  always_comb begin
    in_ready = !flush && !hazard && (!out_valid_q || out_ready);
  end

  // Output register: load on accept, drop on consume, clear on flush; held while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_q       <= uop_d;
      out_valid_q <= 1'b1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: driver pushes expected uops computed by a
// reference model, a negedge monitor compares the presented output and pops on consume.
module tb_alu_issue_stage;

`ifdef ALU_ISSUE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid, in_ready, in_lhs_sel, in_rhs_sel;
  logic [3:0]  in_op;
  logic [4:0]  in_rs1, in_rs2, in_rd, ex_fwd_rd, wb_fwd_rd, out_rd;
  logic [31:0] in_pc, in_imm, rf_rs1_data, rf_rs2_data, ex_fwd_data, wb_fwd_data;
  logic        ex_fwd_valid, ex_fwd_load, wb_fwd_valid, flush;
  logic        out_valid, out_ready;
  logic [3:0]  out_op;
  logic [31:0] out_lhs, out_rhs;

  alu_issue_stage #(.REG_W(32), .OP_W(4), .RADDR_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_lhs_sel(in_lhs_sel),
    .in_rhs_sel(in_rhs_sel), .in_pc(in_pc), .in_imm(in_imm), .rf_rs1_data(rf_rs1_data),
    .rf_rs2_data(rf_rs2_data), .ex_fwd_valid(ex_fwd_valid), .ex_fwd_rd(ex_fwd_rd),
    .ex_fwd_data(ex_fwd_data), .ex_fwd_load(ex_fwd_load), .wb_fwd_valid(wb_fwd_valid),
    .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_op(out_op), .out_lhs(out_lhs), .out_rhs(out_rhs),
    .out_rd(out_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [4:0]  rd;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   n_acc = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference operand value from the architectural rules.
  function automatic logic [31:0] src_val(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 5'd0) return 32'd0;
    if (ex_fwd_valid && !ex_fwd_load && ex_fwd_rd == idx) return ex_fwd_data;
    if (wb_fwd_valid && wb_fwd_rd == idx) return wb_fwd_data;
    return rf;
  endfunction

  function automatic bit model_hazard();
    bit h1, h2;
    h1 = !in_lhs_sel && in_rs1 != 0 && in_rs1 == ex_fwd_rd;
    h2 = !in_rhs_sel && in_rs2 != 0 && in_rs2 == ex_fwd_rd;
    return in_valid && ex_fwd_valid && ex_fwd_load && ex_fwd_rd != 0 && (h1 || h2);
  endfunction

  // Capacity from the number of uops the model says are inside the stage.
  function automatic bit model_ready();
    bit room;
    room = SKID ? (sbq.size() < 2) : (sbq.size() == 0 || out_ready);
    return !flush && !model_hazard() && room;
  endfunction

  // Called at posedge+1 with inputs set; returns at next posedge+1.
  task automatic step();
    bit   acc, fl, er;
    exp_t e;
    #1;
    er = model_ready();
    chk("in_ready", 32'(in_ready), 32'(er));
    acc   = in_valid && er;
    fl    = flush;
    e.op  = in_op;
    e.lhs = in_lhs_sel ? in_pc : src_val(in_rs1, rf_rs1_data);
    e.rhs = in_rhs_sel ? in_imm : src_val(in_rs2, rf_rs2_data);
    e.rd  = in_rd;
    @(posedge clk);
    if (fl) sbq.delete();
    if (acc) begin
      sbq.push_back(e);
      n_acc++;
    end
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_op = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
    in_lhs_sel = 0; in_rhs_sel = 0; in_pc = 0; in_imm = 0;
    rf_rs1_data = 0; rf_rs2_data = 0;
    ex_fwd_valid = 0; ex_fwd_rd = 0; ex_fwd_data = 0; ex_fwd_load = 0;
    wb_fwd_valid = 0; wb_fwd_rd = 0; wb_fwd_data = 0;
    flush = 0; out_ready = 1;
  endtask

  task automatic uop(input logic [3:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic [31:0] r1, input logic [31:0] r2);
    idle();
    in_valid = 1; in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    rf_rs1_data = r1; rf_rs2_data = r2;
  endtask

  task automatic rand_inputs();
    in_valid     = $urandom_range(0, 3) != 0;
    in_op        = 4'($urandom);
    in_rs1       = 5'($urandom_range(0, 7));
    in_rs2       = 5'($urandom_range(0, 7));
    in_rd        = 5'($urandom);
    in_lhs_sel   = $urandom_range(0, 3) == 0;
    in_rhs_sel   = $urandom_range(0, 3) == 0;
    in_pc        = $urandom;
    in_imm       = $urandom;
    rf_rs1_data  = $urandom;
    rf_rs2_data  = $urandom;
    ex_fwd_valid = $urandom_range(0, 1) == 1;
    ex_fwd_rd    = 5'($urandom_range(0, 7));
    ex_fwd_data  = $urandom;
    ex_fwd_load  = $urandom_range(0, 3) == 0;
    wb_fwd_valid = $urandom_range(0, 1) == 1;
    wb_fwd_rd    = 5'($urandom_range(0, 7));
    wb_fwd_data  = $urandom;
    flush        = $urandom_range(0, 15) == 0;
    out_ready    = $urandom_range(0, 3) != 0;
  endtask

  // Monitor: output must mirror the scoreboard head; pop when the consumer takes it.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", 32'(out_valid), 32'(sbq.size() > 0));
      if (out_valid && sbq.size() > 0) begin
        chk("out_op", 32'(out_op), 32'(sbq[0].op));
        chk("out_lhs", out_lhs, sbq[0].lhs);
        chk("out_rhs", out_rhs, sbq[0].rhs);
        chk("out_rd", 32'(out_rd), 32'(sbq[0].rd));
        if (out_ready) void'(sbq.pop_front());
      end
    end
  end

  initial begin
    int acc0;
    idle();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_lhs", out_lhs, 32'd0);
    chk("rst_out_rhs", out_rhs, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 mon_en = 1;

    // Plain register operands.
    uop(4'd0, 5'd3, 5'd4, 5'd9, 32'd10, 32'd20);
    step();
    idle();
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_lhs", out_lhs, 32'd10);
    chk("add_rhs", out_rhs, 32'd20);
    step();

    // EX beats WB; x0 ignores a forward to rd 0.
    uop(4'd1, 5'd5, 5'd1, 5'd2, 32'h11, 32'h22);
    ex_fwd_valid = 1; ex_fwd_rd = 5; ex_fwd_data = 32'hAA;
    wb_fwd_valid = 1; wb_fwd_rd = 5; wb_fwd_data = 32'hBB;
    step();
    idle();
    chk("fwd_ex_prio", out_lhs, 32'hAA);
    uop(4'd1, 5'd0, 5'd1, 5'd2, 32'h33, 32'h44);
    ex_fwd_valid = 1; ex_fwd_rd = 0; ex_fwd_data = 32'd7;
    step();
    idle();
    chk("fwd_x0", out_lhs, 32'd0);
    step();

    // Load-use hazard blocks; using the immediate instead clears it.
    uop(4'd2, 5'd1, 5'd6, 5'd3, 32'h1, 32'h2);
    ex_fwd_valid = 1; ex_fwd_rd = 6; ex_fwd_load = 1;
    #1 chk("hazard_ready", 32'(in_ready), 32'd0);
    step();
    in_rhs_sel = 1; in_imm = 32'h10;
    step();
    idle();
    chk("hazard_imm_rhs", out_rhs, 32'h10);
    step();

    // Stall: output occupied, then three uops offered with out_ready low.
    uop(4'd3, 5'd1, 5'd2, 5'd4, 32'h100, 32'h200);
    out_ready = 0;
    step();
    acc0 = n_acc;
    for (int i = 0; i < 3; i++) begin
      uop(4'(4 + i), 5'(i + 1), 5'(i + 2), 5'(i + 5), 32'(i * 3), 32'(i * 7));
      out_ready = 0;
      step();
    end
    chk("stall_accepts", 32'(n_acc - acc0), SKID ? 32'd1 : 32'd0);
    idle();
    repeat (3) step();

    // Flush with a held uop and a new one offered.
    uop(4'd8, 5'd2, 5'd3, 5'd1, 32'h5, 32'h6);
    out_ready = 0;
    step();
    uop(4'd9, 5'd2, 5'd3, 5'd1, 32'h7, 32'h8);
    out_ready = 0; flush = 1;
    #1 chk("flush_ready", 32'(in_ready), 32'd0);
    step();
    idle();
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    step();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      step();
    end

    // Drain with a bounded budget.
    idle();
    for (int i = 0; i < 10 && sbq.size() > 0; i++) step();
    chk("drain_empty", 32'(sbq.size()), 32'd0);
    step();
    mon_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
